// File: rtl/gshare_pred.sv
// gshare branch predictor: PHT indexed by PC ^ speculative global history,
// plus a tagged, valid-qualified BTB; EX resolution trains both and repairs history.
module gshare_pred #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PHT_SIZE = 1024,
    parameter int unsigned BTB_SIZE = 256,
    parameter int unsigned GHR_LEN  = 8,
    parameter int unsigned CNT_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                ready_o,
    input  logic                fetch_valid_i,
    input  logic [XLEN-1:0]     pc_f_i,
    output logic                pred_taken_f_o,
    output logic [XLEN-1:0]     pred_target_f_o,
    output logic [GHR_LEN-1:0]  pred_ghr_f_o,
    input  logic                resolve_valid_i,
    input  logic [XLEN-1:0]     pc_e_i,
    input  logic                is_cond_e_i,
    input  logic                taken_e_i,
    input  logic [XLEN-1:0]     target_e_i,
    input  logic                pred_taken_e_i,
    input  logic [XLEN-1:0]     pred_target_e_i,
    input  logic [GHR_LEN-1:0]  ghr_e_i,
    output logic                mispredict_o
);

    localparam int unsigned PI   = $clog2(PHT_SIZE);
    localparam int unsigned BI   = $clog2(BTB_SIZE);
    localparam int unsigned TAGW = XLEN - 1 - BI;
    localparam logic [CNT_BITS-1:0] WNT     = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [PI-1:0]         idx_q, idx_d;
    logic [GHR_LEN-1:0]    ghr_q, ghr_d;
    logic [BTB_SIZE-1:0]   btb_valid_q, btb_valid_d;

    // Storage arrays carry no reset: the PHT is swept in INIT, BTB entries are valid-qualified.
    logic [CNT_BITS-1:0]   pht_q     [PHT_SIZE];
    logic                  btb_cond_q[BTB_SIZE];
    logic [TAGW-1:0]       btb_tag_q [BTB_SIZE];
    logic [XLEN-1:0]       btb_tgt_q [BTB_SIZE];

    logic                  run;
    logic [PI-1:0]         f_pidx, e_pidx;
    logic [BI-1:0]         f_bidx, e_bidx;
    logic [TAGW-1:0]       f_tag, e_tag;
    logic                  f_hit, f_cond, f_taken;
    logic [CNT_BITS-1:0]   f_cnt, e_cnt;
    logic                  mispredict;

    logic                  pht_we;
    logic [PI-1:0]         pht_widx;
    logic [CNT_BITS-1:0]   pht_wdata;
    logic                  btb_we;

    logic                  unused_pc_lsb;
    assign unused_pc_lsb = pc_f_i[0] ^ pc_e_i[0];

    assign run = (state_q == ST_RUN);

    always_comb begin
        f_pidx  = pc_f_i[PI:1] ^ PI'(ghr_q);
        f_bidx  = pc_f_i[BI:1];
        f_tag   = pc_f_i[XLEN-1:BI+1];
        f_hit   = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
        f_cond  = btb_cond_q[f_bidx];
        f_cnt   = pht_q[f_pidx];
        f_taken = run && f_hit && (!f_cond || f_cnt[CNT_BITS-1]);

        e_pidx  = pc_e_i[PI:1] ^ PI'(ghr_e_i);
        e_bidx  = pc_e_i[BI:1];
        e_tag   = pc_e_i[XLEN-1:BI+1];
        e_cnt   = pht_q[e_pidx];
        mispredict = run && resolve_valid_i &&
                     ((taken_e_i != pred_taken_e_i) ||
                      (taken_e_i && (target_e_i != pred_target_e_i)));
    end

    assign ready_o         = run;
    assign pred_taken_f_o  = f_taken;
    assign pred_target_f_o = run ? btb_tgt_q[f_bidx] : '0;
    assign pred_ghr_f_o    = run ? ghr_q : '0;
    assign mispredict_o    = mispredict;

    // Single PHT write port, shared by the INIT sweep and EX training.
    always_comb begin
        pht_we    = 1'b0;
        pht_widx  = idx_q;
        pht_wdata = WNT;
        if (!run) begin
            pht_we = 1'b1;
        end else if (resolve_valid_i && is_cond_e_i) begin
            pht_we   = 1'b1;
            pht_widx = e_pidx;
            if (taken_e_i) begin
                pht_wdata = (e_cnt == CNT_MAX) ? e_cnt : e_cnt + CNT_BITS'(1);
            end else begin
                pht_wdata = (e_cnt == '0) ? e_cnt : e_cnt - CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        btb_we      = run && resolve_valid_i && taken_e_i;
        btb_valid_d = btb_valid_q;
        if (btb_we) begin
            btb_valid_d[e_bidx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ghr_d   = ghr_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + PI'(1);
                if (&idx_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_valid_i && f_hit && f_cond) begin
                    ghr_d = GHR_LEN'({ghr_q, f_taken});
                end
                // Repair from the EX snapshot wins over a same-cycle speculative shift.
                if (mispredict) begin
                    ghr_d = is_cond_e_i ? GHR_LEN'({ghr_e_i, taken_e_i}) : ghr_e_i;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            ghr_q       <= '0;
            btb_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ghr_q       <= ghr_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pht_we) begin
            pht_q[pht_widx] <= pht_wdata;
        end
        if (btb_we) begin
            btb_cond_q[e_bidx] <= is_cond_e_i;
            btb_tag_q[e_bidx]  <= e_tag;
            btb_tgt_q[e_bidx]  <= target_e_i;
        end
    end

endmodule

// File: tb/tb_gshare_pred.sv
// Directed bench for gshare_pred: INIT latency, PHT training and saturation,
// BTB fill/alias, speculative history, mispredict repair and mid-sweep reset.
module tb_gshare_pred;

    localparam int XLEN     = 32;
    localparam int PHT_SIZE = 1024;
    localparam int BTB_SIZE = 256;
    localparam int GHR_LEN  = 8;
    localparam int CNT_BITS = 2;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               ready_o;
    logic               fetch_valid_i;
    logic [XLEN-1:0]    pc_f_i;
    logic               pred_taken_f_o;
    logic [XLEN-1:0]    pred_target_f_o;
    logic [GHR_LEN-1:0] pred_ghr_f_o;
    logic               resolve_valid_i;
    logic [XLEN-1:0]    pc_e_i;
    logic               is_cond_e_i;
    logic               taken_e_i;
    logic [XLEN-1:0]    target_e_i;
    logic               pred_taken_e_i;
    logic [XLEN-1:0]    pred_target_e_i;
    logic [GHR_LEN-1:0] ghr_e_i;
    logic               mispredict_o;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    gshare_pred #(
        .XLEN    (XLEN),
        .PHT_SIZE(PHT_SIZE),
        .BTB_SIZE(BTB_SIZE),
        .GHR_LEN (GHR_LEN),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ready_o        (ready_o),
        .fetch_valid_i  (fetch_valid_i),
        .pc_f_i         (pc_f_i),
        .pred_taken_f_o (pred_taken_f_o),
        .pred_target_f_o(pred_target_f_o),
        .pred_ghr_f_o   (pred_ghr_f_o),
        .resolve_valid_i(resolve_valid_i),
        .pc_e_i         (pc_e_i),
        .is_cond_e_i    (is_cond_e_i),
        .taken_e_i      (taken_e_i),
        .target_e_i     (target_e_i),
        .pred_taken_e_i (pred_taken_e_i),
        .pred_target_e_i(pred_target_e_i),
        .ghr_e_i        (ghr_e_i),
        .mispredict_o   (mispredict_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fetch_valid_i   = 1'b0;
        pc_f_i          = '0;
        resolve_valid_i = 1'b0;
        pc_e_i          = '0;
        is_cond_e_i     = 1'b0;
        taken_e_i       = 1'b0;
        target_e_i      = '0;
        pred_taken_e_i  = 1'b0;
        pred_target_e_i = '0;
        ghr_e_i         = '0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic v);
        pc_f_i        = pc;
        fetch_valid_i = v;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic cond, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt, input logic [7:0] ghr);
        resolve_valid_i = 1'b1;
        pc_e_i          = pc;
        is_cond_e_i     = cond;
        taken_e_i       = tk;
        target_e_i      = tgt;
        pred_taken_e_i  = ptk;
        pred_target_e_i = ptgt;
        ghr_e_i         = ghr;
    endtask

    task automatic no_resolve();
        resolve_valid_i = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Counts rising edges until ready_o, then idles inputs before the first RUN edge.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready_o !== 1'b1 && cnt < 4 * PHT_SIZE) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        idle();
        #2;
        rst_i = 1'b1;
        fetch(32'h100, 1'b1);
        resolve(32'h100, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 8'h00);
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_pred_taken", pred_taken_f_o, 0);
        check("rst_pred_target", pred_target_f_o, 0);
        check("rst_pred_ghr", pred_ghr_f_o, 0);
        check("rst_mispredict", mispredict_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready(n);
        check("init_latency", n, PHT_SIZE);

        fetch(32'h100, 1'b0);
        #1;
        check("first_lookup_nt", pred_taken_f_o, 0);
        check("first_lookup_ghr", pred_ghr_f_o, 0);

        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
        #1;
        check("train1_no_bypass", pred_taken_f_o, 0);
        check("train1_no_mispredict", mispredict_o, 0);
        cyc();
        no_resolve();
        #1;
        check("train1_taken", pred_taken_f_o, 1);
        check("train1_target", pred_target_f_o, 32'h80);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
        cyc();
        cyc();
        resolve(32'h100, 1'b1, 1'b0, 32'h123, 1'b0, 32'h55, 8'h00);
        #1;
        check("nt_target_ignored", mispredict_o, 0);
        cyc();
        no_resolve();
        #1;
        check("sat_hi_taken", pred_taken_f_o, 1);
        check("nt_btb_unchanged", pred_target_f_o, 32'h80);
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        cyc();
        no_resolve();
        #1;
        check("dec_to_wnt", pred_taken_f_o, 0);
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
        cyc();
        cyc();
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
        cyc();
        no_resolve();
        #1;
        check("sat_lo_inc1", pred_taken_f_o, 0);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
        cyc();
        no_resolve();
        #1;
        check("sat_lo_inc2", pred_taken_f_o, 1);
        check("ghr_still_zero", pred_ghr_f_o, 0);

        resolve(32'h200, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 8'h00);
        #1;
        check("jal_mispredict", mispredict_o, 1);
        cyc();
        no_resolve();
        fetch(32'h200, 1'b1);
        #1;
        check("jal_taken", pred_taken_f_o, 1);
        check("jal_target", pred_target_f_o, 32'h400);
        cyc();
        fetch(32'h200, 1'b0);
        #1;
        check("jal_no_ghr_shift", pred_ghr_f_o, 0);

        fetch(32'h100, 1'b1);
        #1;
        check("spec_taken", pred_taken_f_o, 1);
        cyc();
        #1;
        check("spec_shift1", pred_ghr_f_o, 8'h01);
        check("spec_new_index_nt", pred_taken_f_o, 0);
        cyc();
        fetch(32'h100, 1'b0);
        #1;
        check("spec_shift2", pred_ghr_f_o, 8'h02);

        fetch(32'h100, 1'b1);
        resolve(32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 8'h5A);
        #1;
        check("dir_mispredict", mispredict_o, 1);
        cyc();
        no_resolve();
        fetch(32'h100, 1'b0);
        #1;
        check("ghr_repair", pred_ghr_f_o, 8'hB4);

        resolve(32'h100, 1'b1, 1'b1, 32'h90, 1'b1, 32'h80, 8'h00);
        #1;
        check("tgt_mispredict", mispredict_o, 1);
        cyc();
        no_resolve();
        #1;
        check("tgt_btb_update", pred_target_f_o, 32'h90);
        check("tgt_ghr_repair", pred_ghr_f_o, 8'h01);

        fetch(32'h200, 1'b0);
        #1;
        check("alias_control_hit", pred_taken_f_o, 1);
        fetch(32'h400, 1'b0);
        #1;
        check("alias_tag_miss", pred_taken_f_o, 0);

        rst_i = 1'b1;
        fetch(32'h200, 1'b1);
        resolve(32'h600, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 8'h00);
        cyc();
        rst_i = 1'b0;
        repeat (PHT_SIZE / 2 - 12) @(posedge clk_i);
        #1;
        check("init_mispredict_gated", mispredict_o, 0);
        check("init_pred_gated", pred_taken_f_o, 0);
        repeat (12) @(posedge clk_i);
        #1;
        check("mid_init_not_ready", ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst2_ready", ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready(n);
        check("restart_latency", n, PHT_SIZE);
        fetch(32'h600, 1'b0);
        #1;
        check("init_resolve_ignored", pred_taken_f_o, 0);
        fetch(32'h200, 1'b0);
        #1;
        check("rst_clears_btb", pred_taken_f_o, 0);
        check("rst_clears_ghr", pred_ghr_f_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
